// File: rtl/conv4x4_window_mac_if.sv
// Window read bus between the 2-D feature buffer and the 4x4 MAC consumer.
// The consumer (master) drives the window address and read enable; the buffer
// (slave) answers combinationally with the four 4-pixel window rows.
interface conv4x4_window_mac_if #(
  parameter int DW       = 16,
  parameter int MEM_ADDR = 3
);
  logic                rd_en;
  logic [MEM_ADDR-1:0] a_add_row;
  logic [MEM_ADDR-1:0] a_add_col;
  logic [4*DW-1:0]     data_out_a;
  logic [4*DW-1:0]     data_out_b;
  logic [4*DW-1:0]     data_out_c;
  logic [4*DW-1:0]     data_out_d;

  modport master (
    output rd_en, a_add_row, a_add_col,
    input  data_out_a, data_out_b, data_out_c, data_out_d
  );

  modport slave (
    input  rd_en, a_add_row, a_add_col,
    output data_out_a, data_out_b, data_out_c, data_out_d
  );
endinterface

// File: rtl/conv4x4_window_mac.sv
// 4x4 sliding-window convolution engine. Scans every window position of the
// feature buffer row-major, reads the window in one LOAD cycle, accumulates
// one kernel row per MAC cycle (4 cycles) and emits one signed result per
// position. The kernel tap file is writable only while no scan is running.
module conv4x4_window_mac #(
  parameter int DW       = 16,
  parameter int MEM_ADDR = 3,
  parameter int IMG_SIZE = 5,
  parameter int ACC_W    = 2*DW+4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      kernel_wr_en,
  input  logic [3:0]                kernel_idx,
  input  logic [DW-1:0]             kernel_data,
  conv4x4_window_mac_if.master      buf_if,
  output logic                      out_valid,
  output logic [ACC_W-1:0]          out_data,
  output logic [MEM_ADDR-1:0]       out_row,
  output logic [MEM_ADDR-1:0]       out_col,
  output logic                      busy,
  output logic                      done
);

  localparam int OSZ = IMG_SIZE - 3;
  localparam logic [MEM_ADDR-1:0] LAST_POS = MEM_ADDR'(OSZ - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_MAC  = 3'd2,
    ST_EMIT = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t              state_r;
  state_t              state_nx_s;
  logic [1:0]          row_cnt_r;
  logic [DW-1:0]       kernel_r [4][4];
  logic [4*DW-1:0]     win_r [4];
  logic [ACC_W-1:0]    acc_r;
  logic [MEM_ADDR-1:0] pos_row_r;
  logic [MEM_ADDR-1:0] pos_col_r;
  logic                rd_en_r;
  logic                busy_r;
  logic                out_valid_r;
  logic                done_r;
  logic [ACC_W-1:0]    out_data_r;
  logic [MEM_ADDR-1:0] out_row_r;
  logic [MEM_ADDR-1:0] out_col_r;

  logic                start_scan_s;
  logic                load_s;
  logic                mac_s;
  logic                mac_last_s;
  logic                emit_s;
  logic                last_pos_s;
  logic [4*DW-1:0]     taps_s;
  logic [ACC_W-1:0]    row_sum_s;

  // Sum of four signed pixel*tap products; col0 sits in the top DW bits of both rows.
  function automatic logic [ACC_W-1:0] row_mac(input logic [4*DW-1:0] pix_row,
                                               input logic [4*DW-1:0] tap_row);
    logic [ACC_W-1:0] sum;
    logic [2*DW-1:0]  pe;
    logic [2*DW-1:0]  te;
    logic [2*DW-1:0]  prod;
    sum = '0;
    for (int c = 0; c < 4; c++) begin
      pe   = {{DW{pix_row[(3-c)*DW + DW-1]}}, pix_row[(3-c)*DW +: DW]};
      te   = {{DW{tap_row[(3-c)*DW + DW-1]}}, tap_row[(3-c)*DW +: DW]};
      prod = pe * te;
      sum  = sum + {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
    end
    return sum;
  endfunction

  // Next-state logic and per-state datapath strobes.
  always_comb begin
    state_nx_s   = state_r;
    start_scan_s = 1'b0;
    load_s       = 1'b0;
    mac_s        = 1'b0;
    emit_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nx_s   = ST_LOAD;
          start_scan_s = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        load_s     = 1'b1;
        state_nx_s = ST_MAC;
      end
      ST_MAC: begin
        mac_s = 1'b1;
        if (row_cnt_r == 2'd3) begin
          state_nx_s = ST_EMIT;
        end else begin
          state_nx_s = ST_MAC;
        end
      end
      ST_EMIT: begin
        emit_s = 1'b1;
        if (last_pos_s) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_LOAD;
        end
      end
      ST_DONE: begin
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Current window row against the matching kernel row.
  always_comb begin
    taps_s    = {kernel_r[row_cnt_r][0], kernel_r[row_cnt_r][1],
                 kernel_r[row_cnt_r][2], kernel_r[row_cnt_r][3]};
    row_sum_s = row_mac(win_r[row_cnt_r], taps_s);
  end

  assign mac_last_s = mac_s && (row_cnt_r == 2'd3);
  assign last_pos_s = (pos_row_r == LAST_POS) && (pos_col_r == LAST_POS);

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Kernel tap file: frozen while a scan runs so every position sees one kernel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < 4; j++) begin
          kernel_r[i][j] <= '0;
        end
      end
    end else if (kernel_wr_en && !busy_r) begin
      kernel_r[kernel_idx[3:2]][kernel_idx[1:0]] <= kernel_data;
    end
  end

  // Window capture at the end of LOAD, then one kernel row accumulated per MAC cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        win_r[i] <= '0;
      end
      acc_r     <= '0;
      row_cnt_r <= 2'd0;
    end else if (load_s) begin
      win_r[0]  <= buf_if.data_out_a;
      win_r[1]  <= buf_if.data_out_b;
      win_r[2]  <= buf_if.data_out_c;
      win_r[3]  <= buf_if.data_out_d;
      acc_r     <= '0;
      row_cnt_r <= 2'd0;
    end else if (mac_s) begin
      acc_r     <= acc_r + row_sum_s;
      row_cnt_r <= row_cnt_r + 2'd1;
    end
  end

  // Window position: cleared on start, advanced row-major after each EMIT, parked at 0 after the last.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_row_r <= '0;
      pos_col_r <= '0;
    end else if (start_scan_s || (emit_s && last_pos_s)) begin
      pos_row_r <= '0;
      pos_col_r <= '0;
    end else if (emit_s) begin
      if (pos_col_r == LAST_POS) begin
        pos_col_r <= '0;
        pos_row_r <= pos_row_r + MEM_ADDR'(1);
      end else begin
        pos_col_r <= pos_col_r + MEM_ADDR'(1);
      end
    end
  end

  // Control outputs registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_en_r     <= 1'b0;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      rd_en_r     <= (state_nx_s == ST_LOAD);
      busy_r      <= (state_nx_s == ST_LOAD) || (state_nx_s == ST_MAC) || (state_nx_s == ST_EMIT);
      out_valid_r <= (state_nx_s == ST_EMIT);
      done_r      <= (state_nx_s == ST_DONE);
    end
  end

  // Result registers load as the last row is accumulated and hold until the next result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data_r <= '0;
      out_row_r  <= '0;
      out_col_r  <= '0;
    end else if (mac_last_s) begin
      out_data_r <= acc_r + row_sum_s;
      out_row_r  <= pos_row_r;
      out_col_r  <= pos_col_r;
    end
  end

  assign buf_if.rd_en     = rd_en_r;
  assign buf_if.a_add_row = pos_row_r;
  assign buf_if.a_add_col = pos_col_r;
  assign out_valid        = out_valid_r;
  assign out_data         = out_data_r;
  assign out_row          = out_row_r;
  assign out_col          = out_col_r;
  assign busy             = busy_r;
  assign done             = done_r;

endmodule

// File: tb/tb_conv4x4_window_mac.sv
// Bench for conv4x4_window_mac: a behavioural 5x5 feature buffer answers window
// reads; fixed vectors, randomized images/kernels against a direct convolution
// model, and hand-written sequences for busy-time writes and mid-scan reset.
module tb_conv4x4_window_mac;
  localparam int DW = 16;
  localparam int MA = 3;
  localparam int AW = 2*DW+4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          kernel_wr_en;
  logic [3:0]    kernel_idx;
  logic [DW-1:0] kernel_data;
  logic          out_valid;
  logic [AW-1:0] out_data;
  logic [MA-1:0] out_row;
  logic [MA-1:0] out_col;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  conv4x4_window_mac_if #(.DW(DW), .MEM_ADDR(MA)) bif ();

  conv4x4_window_mac #(.DW(DW), .MEM_ADDR(MA), .IMG_SIZE(5), .ACC_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .kernel_wr_en(kernel_wr_en),
    .kernel_idx(kernel_idx), .kernel_data(kernel_data), .buf_if(bif),
    .out_valid(out_valid), .out_data(out_data), .out_row(out_row),
    .out_col(out_col), .busy(busy), .done(done)
  );

  logic signed [DW-1:0] tb_pix [5][5];
  logic signed [DW-1:0] tb_k [16];
  logic [4*DW-1:0]      buf_rows [4];

  // Behavioural buffer: combinational window read, zeros when rd_en is low.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      buf_rows[r] = '0;
      for (int c = 0; c < 4; c++) begin
        if (bif.rd_en && (int'(bif.a_add_row) + r < 5) && (int'(bif.a_add_col) + c < 5))
          buf_rows[r][(3-c)*DW +: DW] = tb_pix[int'(bif.a_add_row) + r][int'(bif.a_add_col) + c];
      end
    end
  end
  assign bif.data_out_a = buf_rows[0];
  assign bif.data_out_b = buf_rows[1];
  assign bif.data_out_c = buf_rows[2];
  assign bif.data_out_d = buf_rows[3];

  typedef struct {
    int     img;
    int     ker;
    int     tap;
    longint exp[4];
  } vec_t;
  vec_t tbl [6];

  int n_cmp = 0;
  int n_bad = 0;

  logic [AW-1:0] r_data [4];
  int r_row [4];
  int r_col [4];
  int r_t [4];
  int n_valid, done_t, rd_err, busy_err;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, ".rd_en"}, longint'(bif.rd_en), 0);
    chk({tag, ".busy"}, longint'(busy), 0);
    chk({tag, ".done"}, longint'(done), 0);
    chk({tag, ".out_valid"}, longint'(out_valid), 0);
    chk({tag, ".out_data"}, longint'(out_data), 0);
    chk({tag, ".out_row"}, longint'(out_row), 0);
    chk({tag, ".out_col"}, longint'(out_col), 0);
    chk({tag, ".addr"}, longint'({bif.a_add_row, bif.a_add_col}), 0);
  endtask

  // Direct convolution at output position (orow, ocol).
  function automatic longint model(input int orow, input int ocol);
    longint s;
    s = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        s += longint'(tb_pix[orow+r][ocol+c]) * longint'(tb_k[r*4+c]);
    return s;
  endfunction

  task automatic set_img(input int mode);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        case (mode)
          0: tb_pix[r][c] = 16'sd1;
          1: tb_pix[r][c] = DW'(r*5 + c);
          2: tb_pix[r][c] = 16'hFFFF;
          default: tb_pix[r][c] = 16'h8000;
        endcase
  endtask

  task automatic set_ker(input int mode, input int tap);
    for (int i = 0; i < 16; i++)
      case (mode)
        0: tb_k[i] = 16'sd1;
        1: tb_k[i] = (i == tap) ? 16'sd1 : 16'sd0;
        2: tb_k[i] = 16'sd2;
        default: tb_k[i] = 16'h8000;
      endcase
  endtask

  task automatic prog_kernel(input int ntaps);
    for (int i = 0; i < ntaps; i++) begin
      @(negedge clk);
      kernel_wr_en = 1'b1;
      kernel_idx   = 4'(i);
      kernel_data  = tb_k[i];
    end
    @(negedge clk);
    kernel_wr_en = 1'b0;
  endtask

  // One scan from start; samples #1 after each edge, index k = edges after the start edge.
  task automatic run_scan(input bit wr_with_start, input bit poke_busy);
    n_valid = 0; done_t = -1; rd_err = 0; busy_err = 0;
    for (int i = 0; i < 4; i++) begin
      r_data[i] = '0; r_row[i] = -1; r_col[i] = -1; r_t[i] = -1;
    end
    @(negedge clk);
    start = 1'b1;
    if (wr_with_start) begin
      kernel_wr_en = 1'b1; kernel_idx = 4'd15; kernel_data = tb_k[15];
    end
    @(posedge clk); #1;
    start = 1'b0; kernel_wr_en = 1'b0;
    for (int k = 0; k < 32; k++) begin
      if (out_valid) begin
        if (n_valid < 4) begin
          r_data[n_valid] = out_data; r_row[n_valid] = int'(out_row);
          r_col[n_valid] = int'(out_col); r_t[n_valid] = k;
        end
        n_valid++;
      end
      if (done) done_t = (done_t < 0) ? k : 99;
      if (bif.rd_en !== ((k % 6 == 0) && (k < 24))) rd_err++;
      if (busy !== (k < 24)) busy_err++;
      if (poke_busy && k == 3) begin
        start = 1'b1; kernel_wr_en = 1'b1; kernel_idx = 4'd0; kernel_data = 16'sd5;
      end else begin
        start = 1'b0; kernel_wr_en = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0; kernel_wr_en = 1'b0;
  endtask

  task automatic check_scan(input string tag, input longint exp[4]);
    chk({tag, ".nvalid"}, n_valid, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s.data%0d", tag, i), longint'(r_data[i]), exp[i] & 64'h0000_000F_FFFF_FFFF);
      chk($sformatf("%s.pos%0d", tag, i), longint'(r_row[i] * 8 + r_col[i]), longint'((i / 2) * 8 + (i % 2)));
      chk($sformatf("%s.time%0d", tag, i), r_t[i], 5 + 6*i);
    end
    chk({tag, ".done_t"}, done_t, 24);
    chk({tag, ".rd_en_err"}, rd_err, 0);
    chk({tag, ".busy_err"}, busy_err, 0);
  endtask

  task automatic set_vec(input int i, input int img, input int ker, input int tap,
                         input longint e0, input longint e1, input longint e2, input longint e3);
    tbl[i].img = img; tbl[i].ker = ker; tbl[i].tap = tap;
    tbl[i].exp[0] = e0; tbl[i].exp[1] = e1; tbl[i].exp[2] = e2; tbl[i].exp[3] = e3;
  endtask

  initial begin
    longint exp4 [4];
    int     quiet;

    reset = 1'b1; start = 1'b0; kernel_wr_en = 1'b0; kernel_idx = 4'd0; kernel_data = '0;
    set_img(0); set_ker(1, 99);

    set_vec(0, 0, 0, 0, 16, 16, 16, 16);
    set_vec(1, 1, 1, 0, 0, 1, 5, 6);
    set_vec(2, 1, 1, 3, 3, 4, 8, 9);
    set_vec(3, 1, 1, 15, 18, 19, 23, 24);
    set_vec(4, 2, 2, 0, -32, -32, -32, -32);
    set_vec(5, 3, 3, 0, 64'h4_0000_0000, 64'h4_0000_0000, 64'h4_0000_0000, 64'h4_0000_0000);

    repeat (3) @(posedge clk);
    #1 chk_idle_zero("reset");
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1 chk_idle_zero("post_reset");

    // Fixed vectors
    for (int v = 0; v < 6; v++) begin
      set_img(tbl[v].img);
      set_ker(tbl[v].ker, tbl[v].tap);
      prog_kernel(16);
      run_scan(1'b0, 1'b0);
      check_scan($sformatf("vec%0d", v), tbl[v].exp);
    end

    // Kernel write and start while busy are both ignored
    set_img(0); set_ker(0, 0);
    prog_kernel(16);
    run_scan(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) exp4[i] = 16;
    check_scan("busy_ignore", exp4);

    // Randomized images/kernels; odd runs write the last tap in the start cycle
    for (int it = 0; it < 6; it++) begin
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++)
          tb_pix[r][c] = DW'($urandom_range(0, 65535));
      for (int i = 0; i < 16; i++) tb_k[i] = DW'($urandom_range(0, 65535));
      prog_kernel((it % 2 == 1) ? 15 : 16);
      run_scan(it % 2 == 1, 1'b0);
      for (int i = 0; i < 4; i++) exp4[i] = model(i / 2, i % 2);
      check_scan($sformatf("rand%0d", it), exp4);
    end

    // Reset during MAC of position 2 aborts the scan and clears the kernel
    set_img(0); set_ker(0, 0);
    prog_kernel(16);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (14) @(posedge clk);
    #1 chk("t6.pre_data", longint'(out_data), 16);
    chk("t6.pre_busy", longint'(busy), 1);
    reset = 1'b1;
    #1 chk_idle_zero("t6.reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    quiet = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (out_valid || done || busy || bif.rd_en) quiet++;
    end
    chk("t6.quiet", quiet, 0);
    for (int i = 0; i < 16; i++) tb_k[i] = '0;
    run_scan(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) exp4[i] = 0;
    check_scan("t6.rescan", exp4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
